seg7_scan_mux: RTL and testbench

//  Downstream consumer of the four 7-bit segment PIO out_ports (hour tens/ones, minute tens/ones).

---
 rtl/seg7_scan_mux_pkg.sv | 33 +++
 rtl/seg7_scan_mux_if.sv | 60 ++++++
 rtl/seg7_scan_mux_slot_timer.sv | 65 ++++++
 rtl/seg7_scan_mux.sv | 136 +++++++++++++
 tb/tb_seg7_scan_mux.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/seg7_scan_mux_pkg.sv
// Package seg7_pkg: shared types and constants for the seven-segment scan multiplexer.
//   seg7_t          7-bit segment pattern {g,f,e,d,c,b,a}, bit=1 lit
//   digit_idx_t     scan position 0..3
//   DIG_*           scan position of each display digit
//   SEG7_ZERO       pattern of the numeral "0"
//   SEG7_BLANK      all segments off
//   slot_phase_e    slot FSM state (BLANK gap / DRIVE window)
//   digit_onehot()  active-high one-hot digit select for a scan position
package seg7_pkg;

  typedef logic [6:0] seg7_t;
  typedef logic [1:0] digit_idx_t;

  localparam int NUM_DIGITS = 4;

  localparam digit_idx_t DIG_MIN_ONES  = 2'd0;
  localparam digit_idx_t DIG_MIN_TENS  = 2'd1;
  localparam digit_idx_t DIG_HOUR_ONES = 2'd2;
  localparam digit_idx_t DIG_HOUR_TENS = 2'd3;

  localparam seg7_t SEG7_ZERO  = 7'h3F;
  localparam seg7_t SEG7_BLANK = 7'h00;

  typedef enum logic {
    SLOT_BLANK = 1'b0,
    SLOT_DRIVE = 1'b1
  } slot_phase_e;

  function automatic logic [NUM_DIGITS-1:0] digit_onehot(input digit_idx_t d);
    return 4'b0001 << d;
  endfunction

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Interface seg7_scan_mux_if: bundle between the clock PIO side and the scan multiplexer.
//   seg_hour_tens/seg_hour_ones/seg_min_tens/seg_min_ones  7-bit patterns, bit=1 lit
//   disp_en     0: all digits dark
//   lzb_en      1: hide hour tens while it shows "0"
//   brightness  PWM duty (brightness+1)/16 of the drive window
//   seg_out     shared segment bus (pin polarity)
//   dig_en      one-hot digit select (pin polarity)
//   frame_tick  1-cycle pulse at the end of the hour-tens slot
//   dbg_slot_phase / dbg_digit  live slot FSM state and scan position
//   With SEG7_BLINK_EN defined: blink_mask (per digit) and blink_phase.
// Modports: master = pattern source / display observer, slave = the multiplexer.
//
// Handshake: there is no valid/ready pair on this bundle. All inputs are levels
// sampled on every rising clk edge and affect the pins one cycle later; all
// outputs are valid on every cycle.
interface seg7_scan_mux_if;
  import seg7_pkg::*;

  seg7_t       seg_hour_tens;
  seg7_t       seg_hour_ones;
  seg7_t       seg_min_tens;
  seg7_t       seg_min_ones;
  logic        disp_en;
  logic        lzb_en;
  logic [3:0]  brightness;
  seg7_t       seg_out;
  logic [3:0]  dig_en;
  logic        frame_tick;
  slot_phase_e dbg_slot_phase;
  digit_idx_t  dbg_digit;
`ifdef SEG7_BLINK_EN
  logic [3:0]  blink_mask;
  logic        blink_phase;

  modport master (
    output seg_hour_tens, seg_hour_ones, seg_min_tens, seg_min_ones,
    output disp_en, lzb_en, brightness, blink_mask,
    input  seg_out, dig_en, frame_tick, blink_phase, dbg_slot_phase, dbg_digit
  );

  modport slave (
    input  seg_hour_tens, seg_hour_ones, seg_min_tens, seg_min_ones,
    input  disp_en, lzb_en, brightness, blink_mask,
    output seg_out, dig_en, frame_tick, blink_phase, dbg_slot_phase, dbg_digit
  );
`else
  modport master (
    output seg_hour_tens, seg_hour_ones, seg_min_tens, seg_min_ones,
    output disp_en, lzb_en, brightness,
    input  seg_out, dig_en, frame_tick, dbg_slot_phase, dbg_digit
  );

  modport slave (
    input  seg_hour_tens, seg_hour_ones, seg_min_tens, seg_min_ones,
    input  disp_en, lzb_en, brightness,
    output seg_out, dig_en, frame_tick, dbg_slot_phase, dbg_digit
  );
`endif

endinterface

// File: rtl/seg7_scan_mux_slot_timer.sv
// Module seg7_slot_timer: slot counter, scan position and slot FSM.
//   clk, reset    clock, asynchronous active-high reset
//   pwm_phase     low 4 bits of the slot counter (PWM compare value)
//   digit         current scan position 0..3
//   slot_phase    BLANK for the first BLANK_CYCLES of a slot, DRIVE afterwards
//   slot_start    high on the first cycle of every slot
//   frame_tick    high on the last cycle of the hour-tens slot
module seg7_slot_timer
  import seg7_pkg::*;
#(
  parameter int CLK_DIV      = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic [3:0]  pwm_phase,
  output digit_idx_t  digit,
  output slot_phase_e slot_phase,
  output logic        slot_start,
  output logic        frame_tick
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  // Slot counter resets to 0, so the FSM starts in whichever phase count 0 belongs to.
  localparam slot_phase_e RST_PHASE = (BLANK_CYCLES > 0) ? SLOT_BLANK : SLOT_DRIVE;

  logic [CNT_W-1:0] slot_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             wrap;
  slot_phase_e      state_q;
  slot_phase_e      state_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt <= '0;
      digit    <= DIG_MIN_ONES;
      state_q  <= RST_PHASE;
    end else begin
      slot_cnt <= cnt_nxt;
      state_q  <= state_nxt;
      if (wrap) digit <= digit_idx_t'(digit + 2'd1);
    end
  end

  // The FSM state is derived from the next counter value so that state_q always
  // agrees with slot_cnt in the same cycle.
  always_comb begin
    wrap      = 1'b0;
    cnt_nxt   = slot_cnt + 1'b1;
    state_nxt = SLOT_DRIVE;
    if (slot_cnt == CNT_LAST) begin
      wrap    = 1'b1;
      cnt_nxt = '0;
    end
    if (cnt_nxt < BLANK_END) state_nxt = SLOT_BLANK;
  end

  assign pwm_phase  = slot_cnt[3:0];
  assign slot_phase = state_q;
  assign slot_start = (slot_cnt == '0);
  assign frame_tick = wrap && (digit == DIG_HOUR_TENS);

endmodule

// File: rtl/seg7_scan_mux.sv
// Module seg7_scan_mux: time-multiplexes four 7-segment patterns onto one shared
// segment bus with per-digit enables, inter-digit blanking, 16-level PWM
// brightness and hour-tens leading-zero blanking.
//   clk, reset  clock, asynchronous active-high reset (outputs go dark at once)
//   bus         seg7_scan_mux_if.slave (patterns and controls in, pins out)
// Optional feature macro: SEG7_BLINK_EN adds blink_mask / blink_phase and the
// BLINK_FRAMES parameter; digits with blink_mask[i]=1 go dark while blink_phase=0.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int CLK_DIV        = 1024,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
`ifdef SEG7_BLINK_EN
  ,
  parameter int BLINK_FRAMES   = 64
`endif
) (
  input  logic clk,
  input  logic reset,
  seg7_scan_mux_if.slave bus
);

  localparam seg7_t      SEG_PIN_BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] DIG_PIN_NONE  = DIG_ACTIVE_LOW ? 4'hF  : 4'h0;

  logic [3:0]  pwm_phase;
  digit_idx_t  digit;
  slot_phase_e slot_phase;
  logic        slot_start;
  logic        frame_tick;

  seg7_slot_timer #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .pwm_phase  (pwm_phase),
    .digit      (digit),
    .slot_phase (slot_phase),
    .slot_start (slot_start),
    .frame_tick (frame_tick)
  );

  seg7_t sel_pattern;
  seg7_t shadow_q;
  seg7_t cur_shadow;

  always_comb begin
    sel_pattern = SEG7_BLANK;
    case (digit)
      DIG_MIN_ONES:  sel_pattern = bus.seg_min_ones;
      DIG_MIN_TENS:  sel_pattern = bus.seg_min_tens;
      DIG_HOUR_ONES: sel_pattern = bus.seg_hour_ones;
      DIG_HOUR_TENS: sel_pattern = bus.seg_hour_tens;
      default:       sel_pattern = SEG7_BLANK;
    endcase
  end

  // Pattern is frozen for the whole slot so the shown digit never changes mid-slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) shadow_q <= SEG7_BLANK;
    else if (slot_start) shadow_q <= sel_pattern;
  end

  // On the capture cycle itself the register still holds the previous digit,
  // so use the value being captured; keeps BLANK_CYCLES=0 correct.
  assign cur_shadow = slot_start ? sel_pattern : shadow_q;

  logic blink_dark;

`ifdef SEG7_BLINK_EN
  localparam int FC_W = $clog2(BLINK_FRAMES + 1);
  logic [FC_W-1:0] frame_cnt;
  logic            blink_phase_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt     <= '0;
      blink_phase_q <= 1'b1;
    end else if (frame_tick) begin
      if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt     <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign blink_dark      = !blink_phase_q && bus.blink_mask[digit];
  assign bus.blink_phase = blink_phase_q;
`else
  assign blink_dark = 1'b0;
`endif

  logic       lzb_hit;
  logic       lit;
  seg7_t      seg_v;
  logic [3:0] dig_v;

  always_comb begin
    lzb_hit = bus.lzb_en && (digit == DIG_HOUR_TENS) && (cur_shadow == SEG7_ZERO);
    lit     = (slot_phase == SLOT_DRIVE) && bus.disp_en &&
              (pwm_phase <= bus.brightness) && !lzb_hit && !blink_dark;
    seg_v   = SEG7_BLANK;
    dig_v   = 4'h0;
    if (lit) begin
      seg_v = cur_shadow;
      dig_v = digit_onehot(digit);
    end
  end

  seg7_t      seg_pin_q;
  logic [3:0] dig_pin_q;

  // Pins are registered in their final polarity, so reset drives the dark level directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_pin_q <= SEG_PIN_BLANK;
      dig_pin_q <= DIG_PIN_NONE;
    end else begin
      seg_pin_q <= seg_v ^ {7{SEG_ACTIVE_LOW}};
      dig_pin_q <= dig_v ^ {4{DIG_ACTIVE_LOW}};
    end
  end

  assign bus.seg_out        = seg_pin_q;
  assign bus.dig_en         = dig_pin_q;
  assign bus.frame_tick     = frame_tick;
  assign bus.dbg_slot_phase = slot_phase;
  assign bus.dbg_digit      = digit;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Testbench for seg7_scan_mux (CLK_DIV=32, BLANK_CYCLES=4, both pins active-low).
// Stimulus pushes the expected pin state of every cycle into exp_q; a monitor
// pops and compares one entry per clock. With SEG7_BLINK_EN it runs BLINK_FRAMES=2.
module tb_seg7_scan_mux;
  import seg7_pkg::*;

  localparam int CLK_DIV      = 32;
  localparam int BLANK_CYCLES = 4;
  localparam int FRAME        = 4 * CLK_DIV;
  localparam int BF           = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seg7_scan_mux_if bus();

  seg7_scan_mux #(
    .CLK_DIV        (CLK_DIV),
    .BLANK_CYCLES   (BLANK_CYCLES),
    .SEG_ACTIVE_LOW (1'b1),
    .DIG_ACTIVE_LOW (1'b1)
`ifdef SEG7_BLINK_EN
    ,
    .BLINK_FRAMES   (BF)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          total = 0;
  int          bad   = 0;
  int          t     = 0;
  logic        rand_mode = 1'b0;
  seg7_t       sh [4];
  logic [11:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  function automatic seg7_t pattern_of(input int d);
    case (d)
      0:       return bus.seg_min_ones;
      1:       return bus.seg_min_tens;
      2:       return bus.seg_hour_ones;
      default: return bus.seg_hour_tens;
    endcase
  endfunction

  // Reference: scan time t (cycles since reset release) fixes slot position and digit;
  // each digit shows the pattern it had when its slot began.
  function automatic logic [11:0] model(input int tt);
    int    pos;
    int    d;
    logic  lit;
    seg7_t segp;
    logic [3:0] digp;
    logic  tick;
    pos = tt % CLK_DIV;
    d   = (tt / CLK_DIV) % 4;
    if (pos == 0) sh[d] = pattern_of(d);
    lit = (pos >= BLANK_CYCLES) && bus.disp_en && ((pos % 16) <= int'(bus.brightness)) &&
          !(bus.lzb_en && d == 3 && sh[d] == 7'h3F);
`ifdef SEG7_BLINK_EN
    if ((((tt / FRAME) / BF) % 2) == 1 && bus.blink_mask[d]) lit = 1'b0;
`endif
    segp = lit ? ~sh[d] : 7'h7F;
    digp = lit ? ~(4'b0001 << d) : 4'hF;
    tick = ((tt + 1) % FRAME) == (FRAME - 1);
    return {segp, digp, tick};
  endfunction

  task automatic randomize_inputs();
    if ($urandom_range(0, 39) == 0) begin
      case ($urandom_range(0, 3))
        0: bus.seg_min_ones  = 7'($urandom_range(0, 127));
        1: bus.seg_min_tens  = 7'($urandom_range(0, 127));
        2: bus.seg_hour_ones = 7'($urandom_range(0, 127));
        default: bus.seg_hour_tens = ($urandom_range(0, 1) == 0) ? 7'h3F : 7'($urandom_range(0, 127));
      endcase
    end
    if ($urandom_range(0, 59) == 0) bus.brightness = 4'($urandom_range(0, 15));
    if ($urandom_range(0, 99) == 0) bus.disp_en = ~bus.disp_en;
    if ($urandom_range(0, 79) == 0) bus.lzb_en = ~bus.lzb_en;
`ifdef SEG7_BLINK_EN
    if ($urandom_range(0, 299) == 0) bus.blink_mask = 4'($urandom_range(0, 15));
`endif
  endtask

  // Called at a falling edge: set inputs, record expectation for the next rising edge.
  task automatic step();
    if (rand_mode) randomize_inputs();
    exp_q.push_back(model(t));
    t++;
    @(negedge clk);
  endtask

  // Monitor: one expectation per rising edge, sampled 1 time unit later.
  initial begin
    logic [11:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if ({bus.seg_out, bus.dig_en, bus.frame_tick} !== e) begin
          bad++;
          $display("FAIL scan: got seg=%h dig=%h tick=%b want seg=%h dig=%h tick=%b at %0t",
                   bus.seg_out, bus.dig_en, bus.frame_tick, e[11:5], e[4:1], e[0], $time);
        end
        total++;
        if ($countones(~bus.dig_en) > 1) begin
          bad++;
          $display("FAIL overlap: got dig=%h want at most one selected at %0t", bus.dig_en, $time);
        end
      end
    end
  end

  initial begin
    reset             = 1'b1;
    bus.seg_hour_tens = 7'h06;
    bus.seg_hour_ones = 7'h5B;
    bus.seg_min_tens  = 7'h4F;
    bus.seg_min_ones  = 7'h66;
    bus.disp_en       = 1'b1;
    bus.lzb_en        = 1'b0;
    bus.brightness    = 4'd15;
`ifdef SEG7_BLINK_EN
    bus.blink_mask    = 4'b0011;
`endif
    for (int i = 0; i < 4; i++) sh[i] = 7'h00;

    repeat (5) @(negedge clk);
    check("reset_seg", 32'(bus.seg_out), 32'h7F);
    check("reset_dig", 32'(bus.dig_en), 32'hF);
    check("reset_tick", 32'(bus.frame_tick), 32'h0);
    reset = 1'b0;
    t = 0;

    // Fixed patterns, full brightness.
    repeat (2 * FRAME) step();
    // Reduced duty.
    bus.brightness = 4'd3;
    repeat (FRAME) step();
    // Mid-slot change of digit 0 must not show until its next slot.
    bus.brightness = 4'd15;
    while ((t % FRAME) != 10) step();
    bus.seg_min_ones = 7'h7F;
    repeat (FRAME + 20) step();
    // Leading-zero blanking on and off.
    bus.seg_hour_tens = 7'h3F;
    bus.lzb_en = 1'b1;
    repeat (FRAME) step();
    bus.lzb_en = 1'b0;
    repeat (FRAME) step();
    // Random traffic.
    rand_mode = 1'b1;
    repeat (8 * FRAME) step();

    // Reset in the middle of a slot: pins dark immediately, scan restarts.
    rand_mode = 1'b0;
    while ((t % CLK_DIV) != 13) step();
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_seg", 32'(bus.seg_out), 32'h7F);
    check("async_reset_dig", 32'(bus.dig_en), 32'hF);
    check("async_reset_tick", 32'(bus.frame_tick), 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    t = 0;
    rand_mode = 1'b1;
    repeat (5 * FRAME) step();

    @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
